// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch unit and decode around the fetch queue.
// The master modport is the fetch/decode side; the slave modport is the queue.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instruction;
  logic [6:0]      out_opcode;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_opcode, out_pc, count
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_opcode, out_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry circular FIFO of {pc, instruction} pairs between fetch and decode.
// Presents a NOP bundle whenever empty; flush empties the queue at the next edge.
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter logic [XLEN-1:0] NOP_INSTRUCTION = XLEN'(32'h0000_0013),
  parameter logic [XLEN-1:0] NOP_PC          = XLEN'(32'h0000_0000)
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave bus
);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic              not_empty;
  logic              not_full;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   instr_sel;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != FULL);
  assign push      = bus.in_valid & not_full & ~bus.flush;
  assign pop       = not_empty & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; count alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_pc, bus.in_instruction};
  end

  assign head      = mem[rd_ptr];
  assign instr_sel = not_empty ? head[XLEN-1:0] : NOP_INSTRUCTION;

  assign bus.in_ready        = not_full;
  assign bus.out_valid       = not_empty;
  assign bus.out_instruction = instr_sel;
  assign bus.out_opcode      = instr_sel[6:0];
  assign bus.out_pc          = not_empty ? head[2*XLEN-1:XLEN] : NOP_PC;
  assign bus.count           = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at DEPTH=4 plus a randomized DEPTH=3 run
// checked against a reference queue.
module tb_fetch_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] q_ref [$];

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus_a ();
  fetch_queue_if #(.XLEN(32), .DEPTH(3)) bus_b ();

  fetch_queue #(.XLEN(32), .DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  fetch_queue #(.XLEN(32), .DEPTH(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] make_instr(input logic [31:0] pc);
    return {pc[24:0] ^ 25'h0ABCDE, 7'h33};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] pc, input logic ordy,
                                input logic fl);
    bus_a.in_valid       = iv;
    bus_a.in_pc          = pc;
    bus_a.in_instruction = make_instr(pc);
    bus_a.out_ready      = ordy;
    bus_a.flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_nop_a(input string tag);
    check_output({tag, "_valid"},  64'(bus_a.out_valid), 64'd0);
    check_output({tag, "_instr"},  64'(bus_a.out_instruction), 64'h13);
    check_output({tag, "_opcode"}, 64'(bus_a.out_opcode), 64'h13);
    check_output({tag, "_pc"},     64'(bus_a.out_pc), 64'h0);
    check_output({tag, "_count"},  64'(bus_a.count), 64'd0);
    check_output({tag, "_ready"},  64'(bus_a.in_ready), 64'd1);
  endtask

  initial begin
    logic        iv;
    logic        ordy;
    logic        do_push;
    logic        do_pop;
    logic [31:0] pc;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    bus_b.in_valid       = 1'b0;
    bus_b.in_pc          = '0;
    bus_b.in_instruction = '0;
    bus_b.out_ready      = 1'b0;
    bus_b.flush          = 1'b0;
    #2;
    check_nop_a("reset");
    #10;
    rst = 1'b0;

    // Fill to full with decode stalled; head must stay on the first entry.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      check_output("fill_count", 64'(bus_a.count), 64'(i + 1));
      check_output("fill_head",  64'(bus_a.out_pc), 64'h100);
    end
    check_output("fill_valid",  64'(bus_a.out_valid), 64'd1);
    check_output("fill_instr",  64'(bus_a.out_instruction), 64'(make_instr(32'h100)));
    check_output("fill_opcode", 64'(bus_a.out_opcode), 64'h33);
    check_output("full_ready",  64'(bus_a.in_ready), 64'd0);
    apply_stimulus(1'b1, 32'h110, 1'b0, 1'b0);
    tick();
    check_output("full_block_count", 64'(bus_a.count), 64'd4);
    check_output("full_block_head",  64'(bus_a.out_pc), 64'h100);

    // Pop two, refill across the wrap, then drain completely.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_output("pop1_head",  64'(bus_a.out_pc), 64'h104);
    check_output("pop1_ready", 64'(bus_a.in_ready), 64'd1);
    check_output("pop1_count", 64'(bus_a.count), 64'd3);
    tick();
    check_output("pop2_head",  64'(bus_a.out_pc), 64'h108);
    apply_stimulus(1'b1, 32'h110, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h114, 1'b0, 1'b0);
    tick();
    check_output("wrap_count", 64'(bus_a.count), 64'd4);
    check_output("wrap_ready", 64'(bus_a.in_ready), 64'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output("drain_head", 64'(bus_a.out_pc), 64'h108 + 64'(4 * i));
      check_output("drain_instr", 64'(bus_a.out_instruction),
                   64'(make_instr(32'h108 + 32'(4 * i))));
      tick();
    end
    check_nop_a("drained");

    // Sustained push+pop at occupancy two.
    apply_stimulus(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 32'h308 + 32'(4 * i), 1'b1, 1'b0);
      check_output("stream_head", 64'(bus_a.out_pc), 64'h300 + 64'(4 * i));
      tick();
      check_output("stream_count", 64'(bus_a.count), 64'd2);
    end
    check_output("stream_end_head", 64'(bus_a.out_pc), 64'h328);

    // Flush with concurrent push and pop at occupancy three.
    apply_stimulus(1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    check_output("preflush_count", 64'(bus_a.count), 64'd3);
    apply_stimulus(1'b1, 32'h500, 1'b1, 1'b1);
    tick();
    check_nop_a("flush");
    apply_stimulus(1'b1, 32'h200, 1'b0, 1'b0);
    #1;
    check_output("no_bypass_valid", 64'(bus_a.out_valid), 64'd0);
    tick();
    check_output("postflush_head",  64'(bus_a.out_pc), 64'h200);
    check_output("postflush_count", 64'(bus_a.count), 64'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_output("postflush_empty", 64'(bus_a.out_valid), 64'd0);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    check_output("prereset_count", 64'(bus_a.count), 64'd3);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_nop_a("async_reset");
    #1;
    rst = 1'b0;
    apply_stimulus(1'b1, 32'h700, 1'b0, 1'b0);
    tick();
    check_output("postreset_head",  64'(bus_a.out_pc), 64'h700);
    check_output("postreset_count", 64'(bus_a.count), 64'd1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // DEPTH=3 instance against a reference queue.
    q_ref.delete();
    for (int k = 0; k < 20; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      pc   = 32'h800 + 32'(4 * k);
      bus_b.in_valid       = iv;
      bus_b.in_pc          = pc;
      bus_b.in_instruction = make_instr(pc);
      bus_b.out_ready      = ordy;
      check_output("d3_count", 64'(bus_b.count), 64'(q_ref.size()));
      check_output("d3_valid", 64'(bus_b.out_valid), 64'(q_ref.size() != 0));
      check_output("d3_ready", 64'(bus_b.in_ready), 64'(q_ref.size() != 3));
      check_output("d3_head", 64'(bus_b.out_pc), (q_ref.size() != 0) ? 64'(q_ref[0]) : 64'h0);
      do_push = iv && (q_ref.size() != 3);
      do_pop  = ordy && (q_ref.size() != 0);
      tick();
      if (do_pop)  void'(q_ref.pop_front());
      if (do_push) q_ref.push_back(pc);
    end
    check_output("d3_final_count", 64'(bus_b.count), 64'(q_ref.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between the fetch unit and decode, replacing the single-entry fetch register with a DEPTH-entry FIFO of {pc, instruction} pairs. It uses valid/ready handshakes on both sides and a synchronous flush for branch and jump redirects. Decode sees a NOP bundle whenever the queue is empty or has just been flushed. Lets fetch run ahead of decode stalls without losing instructions.

## Interface
- XLEN, 32, width of instruction and pc fields
- DEPTH, 4, number of entries; any integer >= 2
- NOP_INSTRUCTION, 32'h0000_0013, instruction presented when no valid entry (addi x0,x0,0)
- NOP_PC, 32'h0000_0000, pc presented with the NOP
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch offers an instruction this cycle
- in_ready  output  1  queue accepts; equals (count != DEPTH)
- in_instruction  input  XLEN  fetched instruction
- in_pc  input  XLEN  pc of fetched instruction
- flush  input  1  discard all entries (redirect)
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  decode consumes head this cycle
- out_instruction  output  XLEN  head instruction, or NOP_INSTRUCTION when !out_valid
- out_opcode  output  7  out_instruction[6:0]
- out_pc  output  XLEN  head pc, or NOP_PC when !out_valid
- count  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer with read pointer rd_ptr, write pointer wr_ptr, both 0..DEPTH-1, and a count register.
- Pointer increment wraps explicitly: the pointer goes to 0 when it equals DEPTH-1. DEPTH need not be a power of two.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- push: mem[wr_ptr] <= {in_pc, in_instruction}; wr_ptr advances.
- pop: rd_ptr advances.
- count: +1 on push only, -1 on pop only, unchanged when both or neither.
- Push and pop in the same cycle are legal at any occupancy where each is individually legal.
  - Full queue: in_ready=0, so push is blocked even if pop is asserted. No same-cycle bypass.
  - Empty queue: pop is impossible (out_valid=0). A push is not forwarded to the output in the same cycle.
- Flush: rd_ptr, wr_ptr and count go to 0 at the edge.
  - Flush overrides any simultaneous push and pop; the offered instruction is dropped.
  - in_ready may be high during flush, but nothing is written.
- Output mux is combinational from the registered state only: head = mem[rd_ptr] when count != 0, otherwise the NOP bundle. No input-to-output combinational path.
- out_opcode is always out_instruction[6:0]. It is 7'h13 when empty.
- No other states; control is fully described by count and the pointers.

## Timing
- Reset (async assert, any time): rd_ptr=0, wr_ptr=0, count=0.
  - Immediately after assert: out_valid=0, in_ready=1, out_instruction=NOP_INSTRUCTION, out_opcode=7'h13, out_pc=NOP_PC.
  - Memory contents are not reset.
- Reset mid-operation discards all entries. The first push after deassert lands in entry 0.
- Latency: an instruction pushed at edge N appears on out_* with out_valid=1 in the cycle after edge N (1 cycle).
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- in_ready deasserts in the cycle after the DEPTH-th entry is written. It reasserts in the cycle after a pop from full.
- After flush at edge N: out_valid=0 and NOP outputs from the cycle after edge N. A push is accepted at edge N+1.
- Outputs hold stable while out_valid=1 and out_ready=0 (stall).
- Entries leave in strict FIFO order across pointer wrap-around.

## Test plan
- Reset: assert rst mid-cycle with 3 entries queued -> count=0, out_valid=0, out_instruction=32'h00000013, out_opcode=7'h13, out_pc=0 without waiting for a clock edge.
- Fill and stall (DEPTH=4, out_ready=0): push pc 0x100, 0x104, 0x108, 0x10C -> count=4, in_ready=0. A 5th offer (pc 0x110) is not accepted. out_pc stays 0x100.
- Drain with wrap-around: from full, pop 2, push 0x110 and 0x114, then pop 4 -> out_pc sequence 0x100, 0x104, 0x108, 0x10C, 0x110, 0x114, then out_valid=0.
- Simultaneous push and pop at count=2 over 10 cycles -> count stays 2; output order matches input order; one instruction retired per cycle.
- Flush with concurrent push and pop at count=3 -> next cycle count=0, out_valid=0, NOP outputs. The concurrently offered instruction never appears. The next push (pc 0x200) appears one cycle after its edge.
- Non-power-of-two DEPTH=3: 20 random push/pop cycles checked against a reference queue model -> identical order, count, in_ready and out_valid every cycle.
